// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the multi-cycle instruction sequencer: state encodings,
// trap cause codes and a small state-classification helper.
package pc_sequencer_pkg;

  localparam int STATE_W = 3;
  localparam int WAIT_W  = 8;

  localparam logic [STATE_W-1:0] ST_FETCH  = 3'd0;
  localparam logic [STATE_W-1:0] ST_DECODE = 3'd1;
  localparam logic [STATE_W-1:0] ST_EXEC   = 3'd2;
  localparam logic [STATE_W-1:0] ST_MEM    = 3'd3;
  localparam logic [STATE_W-1:0] ST_WB     = 3'd4;
  localparam logic [STATE_W-1:0] ST_TRAP   = 3'd5;
  localparam logic [STATE_W-1:0] ST_HALT   = 3'd6;

  localparam logic [1:0] TC_NONE    = 2'd0;
  localparam logic [1:0] TC_IMEM    = 2'd1;
  localparam logic [1:0] TC_DMEM    = 2'd2;
  localparam logic [1:0] TC_ILLEGAL = 2'd3;

  // States that hold a memory request open and are therefore subject to timeout.
  function automatic logic waits_on_mem(input logic [STATE_W-1:0] st);
    return (st == ST_FETCH) || (st == ST_MEM);
  endfunction

endpackage

// File: rtl/pc_sequencer_req_timeout.sv
// Shared memory-request wait counter; expire flags the last cycle a request may
// still be acknowledged before the sequencer traps.
module pc_sequencer_req_timeout
  import pc_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_cnt_r;

  // Wait counter: cleared on every state change, advances while a request is open.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt_r <= 8'd0;
    end else if (clear) begin
      wait_cnt_r <= 8'd0;
    end else if (count_en) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign expire = (wait_cnt_r == LIMIT);

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB with trap redirect on
// memory timeout or illegal opcode, a HALT state, and cycle/instret counters.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_branch_taken,
  input  logic             is_jump,
  input  logic             rd_valid,
  input  logic             illegal,
  input  logic             is_halt,
  input  logic             resume,
  output logic             pc_we,
  output logic             pc_imm,
  output logic             trap_sel,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             rf_we,
  output logic [1:0]       trap_cause,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  logic [STATE_W-1:0] state_r;
  logic [STATE_W-1:0] state_nxt_s;
  logic [1:0]         trap_cause_r;
  logic [1:0]         cause_nxt_s;
  logic [CNT_W-1:0]   cycle_cnt_r;
  logic [CNT_W-1:0]   instret_cnt_r;
  logic               expire_s;
  logic               clear_s;
  logic               count_en_s;

  assign clear_s    = (state_nxt_s != state_r);
  assign count_en_s = waits_on_mem(state_r);

  pc_sequencer_req_timeout #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_req_timeout (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (clear_s),
    .count_en(count_en_s),
    .expire  (expire_s)
  );

  // Next-state and trap-cause selection; an ack in the expiry cycle beats the timeout.
  always_comb begin
    state_nxt_s = state_r;
    cause_nxt_s = trap_cause_r;
    case (state_r)
      ST_FETCH: begin
        if (imem_ack) begin
          state_nxt_s = ST_DECODE;
        end else if (expire_s) begin
          state_nxt_s = ST_TRAP;
          cause_nxt_s = TC_IMEM;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (illegal) begin
          state_nxt_s = ST_TRAP;
          cause_nxt_s = TC_ILLEGAL;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_halt) begin
          state_nxt_s = ST_HALT;
        end else if (is_load || is_store) begin
          state_nxt_s = ST_MEM;
        end else begin
          state_nxt_s = ST_WB;
        end
      end
      ST_MEM: begin
        if (dmem_ack) begin
          state_nxt_s = ST_WB;
        end else if (expire_s) begin
          state_nxt_s = ST_TRAP;
          cause_nxt_s = TC_DMEM;
        end else begin
          state_nxt_s = ST_MEM;
        end
      end
      ST_WB:   state_nxt_s = ST_FETCH;
      ST_TRAP: state_nxt_s = ST_FETCH;
      ST_HALT: begin
        if (resume) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      default: state_nxt_s = ST_FETCH;
    endcase
  end

  // State, trap cause and performance counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r       <= ST_FETCH;
      trap_cause_r  <= TC_NONE;
      cycle_cnt_r   <= '0;
      instret_cnt_r <= '0;
    end else begin
      state_r      <= state_nxt_s;
      trap_cause_r <= cause_nxt_s;
      if (state_r != ST_HALT) begin
        cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
      end else begin
        cycle_cnt_r <= cycle_cnt_r;
      end
      if (state_r == ST_WB) begin
        instret_cnt_r <= instret_cnt_r + CNT_W'(1);
      end else begin
        instret_cnt_r <= instret_cnt_r;
      end
    end
  end

  // Control decode; gated by rstn so requests drop the instant reset asserts.
  always_comb begin
    pc_we    = 1'b0;
    pc_imm   = 1'b0;
    trap_sel = 1'b0;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    rf_we    = 1'b0;
    halted   = 1'b0;
    if (rstn) begin
      case (state_r)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ack;
        end
        ST_MEM:   dmem_req = 1'b1;
        ST_WB: begin
          pc_we  = 1'b1;
          pc_imm = is_branch_taken | is_jump;
          rf_we  = rd_valid & ~is_store;
        end
        ST_TRAP: begin
          pc_we    = 1'b1;
          pc_imm   = 1'b1;
          trap_sel = 1'b1;
        end
        ST_HALT: begin
          halted = 1'b1;
          pc_we  = resume;
        end
        default: pc_we = 1'b0;
      endcase
    end else begin
      pc_we    = 1'b0;
      imem_req = 1'b0;
      dmem_req = 1'b0;
    end
  end

  assign trap_cause  = trap_cause_r;
  assign cycle_cnt   = cycle_cnt_r;
  assign instret_cnt = instret_cnt_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with MEM_TIMEOUT=4; outputs checked 2 time
// units after each rising edge, expected values written out by hand.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0, is_load = 1'b0, is_store = 1'b0;
  logic        is_branch_taken = 1'b0, is_jump = 1'b0, rd_valid = 1'b0;
  logic        illegal = 1'b0, is_halt = 1'b0, resume = 1'b0;
  logic        pc_we, pc_imm, trap_sel, imem_req, ir_we, dmem_req, rf_we, halted;
  logic [1:0]  trap_cause;
  logic [31:0] cycle_cnt, instret_cnt;
  logic [7:0]  outs;

  int checks = 0;
  int errors = 0;
  int exp_cyc = 0;

  // outs bit order: pc_we pc_imm trap_sel imem_req ir_we dmem_req rf_we halted
  localparam logic [7:0] O_NONE  = 8'b0000_0000;
  localparam logic [7:0] O_FETCH = 8'b0001_0000;
  localparam logic [7:0] O_IRWE  = 8'b0001_1000;
  localparam logic [7:0] O_MEM   = 8'b0000_0100;
  localparam logic [7:0] O_WBRF  = 8'b1000_0010;
  localparam logic [7:0] O_WB    = 8'b1000_0000;
  localparam logic [7:0] O_BR    = 8'b1100_0000;
  localparam logic [7:0] O_TRAP  = 8'b1110_0000;
  localparam logic [7:0] O_HALT  = 8'b0000_0001;
  localparam logic [7:0] O_RESUM = 8'b1000_0001;

  assign outs = {pc_we, pc_imm, trap_sel, imem_req, ir_we, dmem_req, rf_we, halted};

  pc_sequencer #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .is_load(is_load), .is_store(is_store), .is_branch_taken(is_branch_taken),
    .is_jump(is_jump), .rd_valid(rd_valid), .illegal(illegal), .is_halt(is_halt),
    .resume(resume), .pc_we(pc_we), .pc_imm(pc_imm), .trap_sel(trap_sel),
    .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .rf_we(rf_we),
    .trap_cause(trap_cause), .halted(halted), .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Clock edge in a counting state.
  task automatic tick();
    @(posedge clk);
    #1;
    exp_cyc++;
  endtask

  // Clock edge taken while in HALT: cycle_cnt must not advance.
  task automatic htick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("reset_outs", {24'd0, outs}, {24'd0, O_NONE});
    chk("reset_cyc", cycle_cnt, 32'd0);
    chk("reset_instret", instret_cnt, 32'd0);
    chk("reset_cause", {30'd0, trap_cause}, 32'd0);
    @(negedge clk); rstn = 1'b1; #1;
    chk("fetch_after_reset", {24'd0, outs}, {24'd0, O_FETCH});

    // ALU instruction, ack on second FETCH cycle
    tick(); imem_ack = 1'b1; #1;
    chk("alu_fetch2", {24'd0, outs}, {24'd0, O_IRWE});
    tick(); imem_ack = 1'b0; #1;
    chk("alu_decode", {24'd0, outs}, {24'd0, O_NONE});
    tick(); #1;
    chk("alu_exec", {24'd0, outs}, {24'd0, O_NONE});
    tick(); rd_valid = 1'b1; #1;
    chk("alu_wb", {24'd0, outs}, {24'd0, O_WBRF});
    chk("alu_wb_instret", instret_cnt, 32'd0);
    tick(); rd_valid = 1'b0; #1;
    chk("alu_instret", instret_cnt, 32'd1);
    chk("alu_cycles", cycle_cnt, 32'd5);
    chk("alu_fetch", {24'd0, outs}, {24'd0, O_FETCH});

    // Load, dmem_ack on third MEM cycle
    imem_ack = 1'b1; #1;
    tick(); imem_ack = 1'b0; #1;
    tick(); is_load = 1'b1; #1;
    tick(); is_load = 1'b0; #1;
    chk("ld_mem1", {24'd0, outs}, {24'd0, O_MEM});
    tick(); #1;
    chk("ld_mem2", {24'd0, outs}, {24'd0, O_MEM});
    tick(); dmem_ack = 1'b1; #1;
    chk("ld_mem3", {24'd0, outs}, {24'd0, O_MEM});
    tick(); dmem_ack = 1'b0; rd_valid = 1'b1; #1;
    chk("ld_wb", {24'd0, outs}, {24'd0, O_WBRF});
    tick(); rd_valid = 1'b0; #1;
    chk("ld_instret", instret_cnt, 32'd2);

    // Store with rd_valid set: no register write
    imem_ack = 1'b1; #1;
    tick(); imem_ack = 1'b0; #1;
    tick(); is_store = 1'b1; #1;
    tick(); dmem_ack = 1'b1; #1;
    chk("st_mem", {24'd0, outs}, {24'd0, O_MEM});
    tick(); dmem_ack = 1'b0; rd_valid = 1'b1; #1;
    chk("st_wb", {24'd0, outs}, {24'd0, O_WB});
    tick(); rd_valid = 1'b0; is_store = 1'b0; #1;
    chk("st_instret", instret_cnt, 32'd3);

    // Taken branch
    imem_ack = 1'b1; #1;
    tick(); imem_ack = 1'b0; #1;
    tick(); #1;
    tick(); is_branch_taken = 1'b1; #1;
    chk("br_wb", {24'd0, outs}, {24'd0, O_BR});
    tick(); is_branch_taken = 1'b0; #1;
    chk("br_instret", instret_cnt, 32'd4);
    chk("br_cycles", cycle_cnt, exp_cyc[31:0]);

    // imem timeout: four FETCH cycles then TRAP
    tick(); tick(); tick(); #1;
    chk("to_fetch4", {24'd0, outs}, {24'd0, O_FETCH});
    tick(); #1;
    chk("to_trap", {24'd0, outs}, {24'd0, O_TRAP});
    chk("to_cause", {30'd0, trap_cause}, 32'd1);
    chk("to_instret", instret_cnt, 32'd4);
    tick(); #1;
    chk("to_back_fetch", {24'd0, outs}, {24'd0, O_FETCH});
    chk("to_cause_hold", {30'd0, trap_cause}, 32'd1);

    // Ack on the fourth FETCH cycle wins over timeout
    tick(); tick(); tick(); imem_ack = 1'b1; #1;
    chk("ack4_irwe", {24'd0, outs}, {24'd0, O_IRWE});
    tick(); imem_ack = 1'b0; illegal = 1'b1; #1;
    chk("ack4_decode", {24'd0, outs}, {24'd0, O_NONE});
    // Illegal opcode in DECODE
    tick(); illegal = 1'b0; #1;
    chk("ill_trap", {24'd0, outs}, {24'd0, O_TRAP});
    chk("ill_cause", {30'd0, trap_cause}, 32'd3);
    tick(); #1;

    // Halt: higher priority than load in EXEC
    imem_ack = 1'b1; #1;
    tick(); imem_ack = 1'b0; #1;
    tick(); is_halt = 1'b1; is_load = 1'b1; #1;
    tick(); is_halt = 1'b0; is_load = 1'b0; #1;
    chk("halt_outs", {24'd0, outs}, {24'd0, O_HALT});
    for (int i = 0; i < 10; i++) begin
      htick();
      chk("halt_cyc_frozen", cycle_cnt, exp_cyc[31:0]);
    end
    resume = 1'b1; #1;
    chk("halt_resume", {24'd0, outs}, {24'd0, O_RESUM});
    htick(); resume = 1'b0; #1;
    chk("resume_fetch", {24'd0, outs}, {24'd0, O_FETCH});
    tick(); #1;
    chk("resume_cyc", cycle_cnt, exp_cyc[31:0]);
    resume = 1'b1; #1;
    chk("resume_ignored", {24'd0, outs}, {24'd0, O_FETCH});
    resume = 1'b0;

    // Reset asserted in MEM
    imem_ack = 1'b1; #1;
    tick(); imem_ack = 1'b0; #1;
    tick(); is_load = 1'b1; #1;
    tick(); is_load = 1'b0; #1;
    chk("rst_pre_mem", {24'd0, outs}, {24'd0, O_MEM});
    rstn = 1'b0; #1;
    chk("rst_drop_req", {24'd0, outs}, {24'd0, O_NONE});
    chk("rst_cyc", cycle_cnt, 32'd0);
    chk("rst_instret", instret_cnt, 32'd0);
    chk("rst_cause", {30'd0, trap_cause}, 32'd0);
    @(negedge clk); rstn = 1'b1; #1;
    chk("rst_release_fetch", {24'd0, outs}, {24'd0, O_FETCH});
    tick(); #1;
    chk("rst_release_cyc", cycle_cnt, 32'd1);
    chk("rst_release_state", {24'd0, outs}, {24'd0, O_FETCH});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle control FSM for the RV32 core. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB.
- It drives the program counter's write-enable and immediate-select, the instruction-register load, the register-file write and both memory request handshakes.
- It converts memory timeouts and illegal instructions into a one-cycle trap redirect, and keeps cycle and retired-instruction counters.

Parameters:
- MEM_TIMEOUT, 16, max cycles a memory request may wait for ack before trapping (legal range 2..255).
- CNT_W, 32, width of cycle_cnt and instret_cnt.

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- imem_ack  in  1  instruction memory data valid
- dmem_ack  in  1  data memory access complete
- is_load  in  1  decoded load, valid in EXEC
- is_store  in  1  decoded store, valid in EXEC
- is_branch_taken  in  1  branch resolved taken, valid in WB
- is_jump  in  1  JAL/JALR, valid in WB
- rd_valid  in  1  instruction writes rd, valid in WB
- illegal  in  1  decoder flags illegal opcode, valid in DECODE
- is_halt  in  1  EBREAK/halt decoded, valid in EXEC
- resume  in  1  leave HALT
- pc_we  out  1  program counter write enable
- pc_imm  out  1  program counter loads external immediate address
- trap_sel  out  1  immediate address mux selects trap vector
- imem_req  out  1  instruction fetch request
- ir_we  out  1  instruction register load
- dmem_req  out  1  data memory request
- rf_we  out  1  register file write enable
- trap_cause  out  2  0 none, 1 imem timeout, 2 dmem timeout, 3 illegal
- halted  out  1  FSM in HALT
- cycle_cnt  out  CNT_W  free-running cycle count
- instret_cnt  out  CNT_W  retired instruction count

Behaviour:
- Reset (async, rstn=0): state=FETCH, wait counter=0, trap_cause=0, both counters=0.
- Outputs are decoded from the registered state, except ir_we, which is state==FETCH && imem_ack. All outputs are 0 during reset.
- FETCH:
  - imem_req=1.
  - On imem_ack: ir_we=1, next state DECODE.
  - Else the wait counter increments. If the counter reaches MEM_TIMEOUT-1 with no ack: next state TRAP, trap_cause<=1.
  - If ack and timeout occur in the same cycle, ack wins.
- DECODE: one cycle. If illegal: next state TRAP, trap_cause<=3. Else next state EXEC.
- EXEC: one cycle. Next state by priority: is_halt -> HALT; is_load|is_store -> MEM; otherwise WB.
- MEM:
  - dmem_req=1 held until dmem_ack, then next state WB.
  - Timeout handling is identical to FETCH, with trap_cause<=2.
- WB: one cycle.
  - pc_we=1; pc_imm=is_branch_taken|is_jump.
  - rf_we=rd_valid & ~is_store.
  - instret_cnt increments. Next state FETCH.
- TRAP: one cycle. pc_we=1, pc_imm=1, trap_sel=1, rf_we=0. No retire. Next state FETCH. trap_cause holds until the next trap or reset.
- HALT:
  - halted=1, all enables 0.
  - On resume: pc_we=1, pc_imm=0 (PC steps past the halt instruction), next state FETCH.
  - resume is ignored outside HALT.
- Wait counter clears on every state change. Width is 8 bits.
- cycle_cnt increments every cycle except in HALT. Both counters wrap modulo 2^CNT_W without flag.
- Reset asserted mid-request drops imem_req/dmem_req asynchronously. No pending state survives reset.
- Illegal/undefined state encodings recover to FETCH on the next clock.

Decomposition:
- Shared package (defines include): state encodings (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5, HALT=6) and trap_cause codes.
- One sub-module is natural: req_timeout (counter, clear, expire output), instantiated once and shared by FETCH and MEM.

Test Plan:
- ALU instruction, imem_ack on the 2nd FETCH cycle -> FETCH(2 cycles), DECODE, EXEC, WB = 5 cycles. pc_we=1, pc_imm=0, rf_we=1 in WB only. instret_cnt 0->1.
- Load with dmem_ack after 3 cycles -> MEM lasts 3 cycles with dmem_req=1; WB rf_we=1. Store with rd_valid=1 -> rf_we=0.
- Taken branch -> WB with pc_we=1, pc_imm=1, trap_sel=0.
- imem_ack held low, MEM_TIMEOUT=4 -> TRAP entered after 4 FETCH cycles; one cycle of pc_we=pc_imm=trap_sel=1; trap_cause=1; instret unchanged. Ack on the 4th cycle -> DECODE, no trap.
- illegal=1 in DECODE -> TRAP, trap_cause=3. is_halt in EXEC -> halted=1, cycle_cnt frozen for 10 cycles. resume -> pc_we=1, pc_imm=0, back to FETCH.
- rstn pulsed low while in MEM with dmem_req=1 -> dmem_req=0 immediately; after release, state FETCH, counters 0, trap_cause 0.
